regwb_scoreboard: RTL and testbench
===================================

Name: regwb_scoreboard

Overview:
- Parametrised register-writeback checker for processor lockstep verification.
- Expected writebacks (addr, data) from the processor model are queued in an in-order FIFO. Actual writebacks from the processor debug/writeback port are popped and compared against them.
- Reports per-entry mismatches, unexpected writebacks, overflow and timeout, and keeps saturating pass/fail counters.
- Sits between processor_model and the PROCESSOR writeback tap in the processor bench. Replaces the per-change fork/compare check with a buffered, cycle-exact one.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 64, maximum cycles the FIFO head may wait for an actual writeback.
- CNT_W, 16, width of the match and error counters.

Ports:
- Clock  in  1  clock.
- nReset  in  1  reset; synchronous, active-high.
- ExpValid  in  1  model writeback strobe.
- ExpAddr  in  ADDR_W  model destination register.
- ExpData  in  DATA_W  model written value.
- ActValid  in  1  RTL writeback strobe.
- ActAddr  in  ADDR_W  RTL destination register.
- ActData  in  DATA_W  RTL written value.
- Level  out  $clog2(DEPTH)+1  FIFO occupancy.
- MatchCount  out  CNT_W  compares passed.
- ErrCount  out  CNT_W  compares failed, including unexpected writebacks.
- Error  out  1  one-cycle pulse on any failed compare.
- ErrAddr  out  ADDR_W  address of the last failure.
- ErrExp  out  DATA_W  expected data of the last failure.
- ErrAct  out  DATA_W  actual data of the last failure.
- Unexpected  out  1  last failure had an empty FIFO.
- Overflow  out  1  sticky; a push was dropped.
- Timeout  out  1  sticky; head waited TIMEOUT cycles.
- Idle  out  1  FIFO empty and not in FAIL.

Behaviour:
- Reset: applied on the Clock edge while nReset=1. All outputs go to 0 except Idle=1. FIFO is emptied, wait counter cleared, state IDLE. Reset applied mid-operation discards all queued entries with no Error pulse.
- Push: on ExpValid, {ExpAddr, ExpData} is written at the tail.
- Pop/compare: on ActValid, the head entry is compared with {ActAddr, ActData} in the same cycle.
  - Result is registered: Error, ErrAddr/ErrExp/ErrAct and the counters update one cycle after ActValid (latency 1).
  - Match: MatchCount+1.
  - Mismatch on address or data: ErrCount+1, Error=1, ErrAddr=expected addr, ErrExp=expected data, ErrAct=ActData, Unexpected=0.
- ActValid with FIFO empty and no same-cycle push:
  - Unexpected=1, ErrCount+1, Error=1, ErrAddr=ActAddr, ErrExp=0, ErrAct=ActData.
  - No pop occurs.
- ActValid with FIFO empty and same-cycle ExpValid: the comparison is made directly against the incoming expected entry (bypass). Nothing is stored; Level stays 0.
- Full (Level==DEPTH):
  - Push with a same-cycle pop: accepted.
  - Push without a pop: dropped, Overflow=1 (sticky until reset), Level unchanged.
- Pointers: wrap modulo DEPTH. Level is updated +1, -1 or unchanged on simultaneous push and pop.
- Counters: saturate at all-ones.
- FSM:
  - IDLE: FIFO empty. Goes to WAIT when Level becomes nonzero.
  - WAIT: wait counter increments each cycle without a pop and clears on every pop. Goes back to IDLE when Level returns to 0. Goes to FAIL when the counter reaches TIMEOUT-1 without a pop.
  - FAIL: Timeout=1. Compares continue and counters still update. Only reset exits FAIL. Idle=0.
- Idle is registered and equals (state==IDLE).

Optional Feature:
- Macro: REG0_FILTER_EN.
- When defined:
  - ExpValid with ExpAddr==0 is ignored (no push).
  - ActValid with ActAddr==0 is ignored (no pop, no compare, no counter change). This models the hardwired $0.
- When undefined: address 0 is queued and compared like any other register.

Test Plan:
- Push (3, 0x0000_00AA) then, 2 cycles later, Act (3, 0x0000_00AA) -> one cycle later MatchCount=1, Error=0, Level=0, Idle=1.
- Push (7, 0x1234_5678), then Act (7, 0x1234_5679) -> Error pulse, ErrCount=1, ErrAddr=7, ErrExp=0x12345678, ErrAct=0x12345679, Unexpected=0.
- 8 pushes with no pops (DEPTH=8), then a 9th push -> Overflow=1, Level=8. Then push+pop in the same cycle -> Level stays 8, Overflow stays 1.
- Act (4, 5) with the FIFO empty -> Error, Unexpected=1, ErrExp=0, ErrCount=1. Same-cycle Exp/Act (4, 5) with the FIFO empty -> MatchCount+1, Level=0.
- Push one entry, no Act for 64 cycles -> Timeout=1 in the 64th cycle, Idle=0. Subsequent matching Act -> MatchCount+1, Timeout stays 1. Reset -> all cleared, Idle=1.
- With REG0_FILTER_EN: Exp (0, 0xFFFF_FFFF) and Act (0, 0x1) -> no count change, Level=0, Error=0. Without REG0_FILTER_EN: same stimulus -> Error, ErrAddr=0.

Source files
------------

// File: rtl/regwb_scoreboard.sv
// Register-writeback scoreboard: queues expected (addr, data) writebacks and checks actual ones in order.
// Optional build macro REG0_FILTER_EN: ignore expected/actual writebacks that target register 0.
module regwb_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     ExpValid,
  input  logic [ADDR_W-1:0]        ExpAddr,
  input  logic [DATA_W-1:0]        ExpData,
  input  logic                     ActValid,
  input  logic [ADDR_W-1:0]        ActAddr,
  input  logic [DATA_W-1:0]        ActData,
  output logic [$clog2(DEPTH):0]   Level,
  output logic [CNT_W-1:0]         MatchCount,
  output logic [CNT_W-1:0]         ErrCount,
  output logic                     Error,
  output logic [ADDR_W-1:0]        ErrAddr,
  output logic [DATA_W-1:0]        ErrExp,
  output logic [DATA_W-1:0]        ErrAct,
  output logic                     Unexpected,
  output logic                     Overflow,
  output logic                     Timeout,
  output logic                     Idle
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_error;
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_exp;
  logic [DATA_W-1:0] r_err_act;
  logic              r_unexpected;
  logic              r_overflow;
  logic              r_timeout;
  logic              r_idle;
  logic [WAIT_W-1:0] r_wait;
  state_t            r_state;

  logic              w_push_req;
  logic              w_act;
  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_unexp;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_mismatch;
  logic [ENT_W-1:0]  w_ref;
  logic [LVL_W-1:0]  w_level_nxt;

  // Request qualification, bypass/pop/push decisions and the same-cycle compare.
  always_comb begin
    w_push_req = ExpValid;
    w_act      = ActValid;
`ifdef REG0_FILTER_EN
    w_push_req = ExpValid & (ExpAddr != {ADDR_W{1'b0}});
    w_act      = ActValid & (ActAddr != {ADDR_W{1'b0}});
`endif
    w_empty  = (r_level == {LVL_W{1'b0}});
    w_full   = (r_level == LVL_W'(DEPTH));
    w_bypass = w_act & w_empty & w_push_req;
    w_unexp  = w_act & w_empty & ~w_push_req;
    w_pop    = w_act & ~w_empty;
    w_push   = w_push_req & ~w_bypass & (~w_full | w_pop);
    w_drop   = w_push_req & w_full & ~w_pop;
    if (w_empty) begin
      w_ref = {ExpAddr, ExpData};
    end else begin
      w_ref = r_mem[r_rd_ptr];
    end
    w_mismatch = w_act & ~w_unexp & (w_ref != {ActAddr, ActData});
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // FIFO storage; contents are only read while the occupancy says they are valid.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {ExpAddr, ExpData};
    end
  end

  // Pointers, occupancy, compare results, counters and sticky overflow.
  always_ff @(posedge Clock) begin
    if (nReset) begin
      r_wr_ptr     <= {PTR_W{1'b0}};
      r_rd_ptr     <= {PTR_W{1'b0}};
      r_level      <= {LVL_W{1'b0}};
      r_match_cnt  <= {CNT_W{1'b0}};
      r_err_cnt    <= {CNT_W{1'b0}};
      r_error      <= 1'b0;
      r_err_addr   <= {ADDR_W{1'b0}};
      r_err_exp    <= {DATA_W{1'b0}};
      r_err_act    <= {DATA_W{1'b0}};
      r_unexpected <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_error <= w_unexp | w_mismatch;
      if (w_unexp) begin
        r_err_cnt    <= sat_inc(r_err_cnt);
        r_err_addr   <= ActAddr;
        r_err_exp    <= {DATA_W{1'b0}};
        r_err_act    <= ActData;
        r_unexpected <= 1'b1;
      end else if (w_mismatch) begin
        r_err_cnt    <= sat_inc(r_err_cnt);
        r_err_addr   <= w_ref[ENT_W-1:DATA_W];
        r_err_exp    <= w_ref[DATA_W-1:0];
        r_err_act    <= ActData;
        r_unexpected <= 1'b0;
      end else if (w_act) begin
        r_match_cnt <= sat_inc(r_match_cnt);
      end
    end
  end

  // Head-of-queue watchdog: waits while entries are pending, latches FAIL on starvation.
  always_ff @(posedge Clock) begin
    if (nReset) begin
      r_state   <= S_IDLE;
      r_wait    <= {WAIT_W{1'b0}};
      r_timeout <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait <= {WAIT_W{1'b0}};
          if (w_level_nxt != {LVL_W{1'b0}}) begin
            r_state <= S_WAIT;
            r_idle  <= 1'b0;
          end else begin
            r_idle  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_level_nxt == {LVL_W{1'b0}}) begin
            r_state <= S_IDLE;
            r_wait  <= {WAIT_W{1'b0}};
            r_idle  <= 1'b1;
          end else if (w_pop) begin
            r_wait  <= {WAIT_W{1'b0}};
          end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            r_state   <= S_FAIL;
            r_timeout <= 1'b1;
          end else begin
            r_wait  <= r_wait + WAIT_W'(1);
          end
        end
        S_FAIL: begin
          r_timeout <= 1'b1;
          r_idle    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_wait  <= {WAIT_W{1'b0}};
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign Level      = r_level;
  assign MatchCount = r_match_cnt;
  assign ErrCount   = r_err_cnt;
  assign Error      = r_error;
  assign ErrAddr    = r_err_addr;
  assign ErrExp     = r_err_exp;
  assign ErrAct     = r_err_act;
  assign Unexpected = r_unexpected;
  assign Overflow   = r_overflow;
  assign Timeout    = r_timeout;
  assign Idle       = r_idle;

endmodule

// File: tb/tb_regwb_scoreboard.sv
// Bench for regwb_scoreboard: directed scenarios plus random traffic against a queue-based reference model.
module tb_regwb_scoreboard;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic              Clock;
  logic              nReset;
  logic              ExpValid;
  logic [ADDR_W-1:0] ExpAddr;
  logic [DATA_W-1:0] ExpData;
  logic              ActValid;
  logic [ADDR_W-1:0] ActAddr;
  logic [DATA_W-1:0] ActData;
  logic [3:0]        Level;
  logic [CNT_W-1:0]  MatchCount;
  logic [CNT_W-1:0]  ErrCount;
  logic              Error;
  logic [ADDR_W-1:0] ErrAddr;
  logic [DATA_W-1:0] ErrExp;
  logic [DATA_W-1:0] ErrAct;
  logic              Unexpected;
  logic              Overflow;
  logic              Timeout;
  logic              Idle;

  regwb_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .nReset(nReset),
    .ExpValid(ExpValid), .ExpAddr(ExpAddr), .ExpData(ExpData),
    .ActValid(ActValid), .ActAddr(ActAddr), .ActData(ActData),
    .Level(Level), .MatchCount(MatchCount), .ErrCount(ErrCount), .Error(Error),
    .ErrAddr(ErrAddr), .ErrExp(ErrExp), .ErrAct(ErrAct), .Unexpected(Unexpected),
    .Overflow(Overflow), .Timeout(Timeout), .Idle(Idle)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Reference state: pending writebacks as a plain queue plus the reported results.
  ent_t              q[$];
  logic [CNT_W-1:0]  m_match, m_err;
  logic              m_error, m_unexp, m_ovf, m_fail;
  logic [ADDR_W-1:0] m_eaddr;
  logic [DATA_W-1:0] m_eexp, m_eact;
  int                stall;
  int                checks = 0;
  int                errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_match = 16'd0; m_err = 16'd0;
    m_error = 1'b0; m_unexp = 1'b0; m_ovf = 1'b0; m_fail = 1'b0;
    m_eaddr = 5'd0; m_eexp = 32'd0; m_eact = 32'd0;
    stall = 0;
  endtask

  task automatic model_step(input bit ev, input ent_t e, input bit av, input ent_t a);
    bit   pr, ar, was_empty, popped, have;
    ent_t ref_e;
    pr = ev; ar = av;
`ifdef REG0_FILTER_EN
    if (e.a == 5'd0) pr = 1'b0;
    if (a.a == 5'd0) ar = 1'b0;
`endif
    was_empty = (q.size() == 0);
    popped = 1'b0;
    m_error = 1'b0;
    ref_e = '0;
    if (ar) begin
      have = 1'b1;
      if (!was_empty) begin
        ref_e = q.pop_front();
        popped = 1'b1;
      end else if (pr) begin
        ref_e = e;
        pr = 1'b0;
      end else begin
        have = 1'b0;
      end
      if (!have) begin
        m_err = bump(m_err); m_error = 1'b1; m_unexp = 1'b1;
        m_eaddr = a.a; m_eexp = 32'd0; m_eact = a.d;
      end else if (ref_e == a) begin
        m_match = bump(m_match);
      end else begin
        m_err = bump(m_err); m_error = 1'b1; m_unexp = 1'b0;
        m_eaddr = ref_e.a; m_eexp = ref_e.d; m_eact = a.d;
      end
    end
    if (pr) begin
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1'b1;
    end
    if (!was_empty && !popped) stall++;
    else stall = 0;
    if (stall >= TIMEOUT) m_fail = 1'b1;
  endtask

  task automatic check_all();
    check_val("Level",      64'(Level),      64'(q.size()));
    check_val("MatchCount", 64'(MatchCount), 64'(m_match));
    check_val("ErrCount",   64'(ErrCount),   64'(m_err));
    check_val("Error",      64'(Error),      64'(m_error));
    check_val("ErrAddr",    64'(ErrAddr),    64'(m_eaddr));
    check_val("ErrExp",     64'(ErrExp),     64'(m_eexp));
    check_val("ErrAct",     64'(ErrAct),     64'(m_eact));
    check_val("Unexpected", 64'(Unexpected), 64'(m_unexp));
    check_val("Overflow",   64'(Overflow),   64'(m_ovf));
    check_val("Timeout",    64'(Timeout),    64'(m_fail));
    check_val("Idle",       64'(Idle),       64'(!m_fail && q.size() == 0));
  endtask

  task automatic cycle(input bit ev, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                       input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
    ExpValid = ev; ExpAddr = ea; ExpData = ed;
    ActValid = av; ActAddr = aa; ActData = ad;
    @(posedge Clock);
    model_step(ev, {ea, ed}, av, {aa, ad});
    #1;
    ExpValid = 1'b0; ActValid = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    nReset = 1'b1;
    ExpValid = 1'b0; ActValid = 1'b0;
    @(posedge Clock);
    model_reset();
    #1;
    nReset = 1'b0;
    check_all();
  endtask

  initial begin
    nReset = 1'b1;
    ExpValid = 1'b0; ExpAddr = 5'd0; ExpData = 32'd0;
    ActValid = 1'b0; ActAddr = 5'd0; ActData = 32'd0;
    @(posedge Clock);
    do_reset();
    check_val("rst_idle", 64'(Idle), 64'd1);

    // Match after a short delay.
    cycle(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_00AA);
    check_val("tp_match_cnt", 64'(MatchCount), 64'd1);
    check_val("tp_match_idle", 64'(Idle), 64'd1);

    // Data mismatch.
    do_reset();
    cycle(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234_5679);
    check_val("tp_mis_err", 64'(Error), 64'd1);
    check_val("tp_mis_exp", 64'(ErrExp), 64'h1234_5678);

    // Fill, overflow, then push+pop while full.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 5'(i + 1), 32'(i * 17), 1'b0, 5'd0, 32'd0);
    check_val("tp_ovf", 64'(Overflow), 64'd1);
    check_val("tp_ovf_level", 64'(Level), 64'd8);
    cycle(1'b1, 5'd20, 32'h55, 1'b1, 5'd1, 32'd0);
    check_val("tp_full_pushpop", 64'(Level), 64'd8);

    // Unexpected, then bypass compare.
    do_reset();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd5);
    check_val("tp_unexp", 64'(Unexpected), 64'd1);
    cycle(1'b1, 5'd4, 32'd5, 1'b1, 5'd4, 32'd5);
    check_val("tp_bypass_lvl", 64'(Level), 64'd0);

    // Timeout, compares continue in FAIL, reset clears it.
    do_reset();
    cycle(1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("tp_tmo_early", 64'(Timeout), 64'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_val("tp_tmo", 64'(Timeout), 64'd1);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE);
    check_val("tp_tmo_sticky", 64'(Timeout), 64'd1);
    check_val("tp_tmo_idle", 64'(Idle), 64'd0);
    do_reset();

    // Register 0 handling.
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h1);
`ifdef REG0_FILTER_EN
    check_val("tp_r0_err", 64'(Error), 64'd0);
`else
    check_val("tp_r0_err", 64'(Error), 64'd1);
`endif

    // Random traffic, mostly well-formed with occasional corruption and resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit                ev, av;
      logic [ADDR_W-1:0] ea, aa;
      logic [DATA_W-1:0] ed, ad;
      ev = ($urandom_range(0, 99) < 45);
      av = ($urandom_range(0, 99) < 40);
      ea = 5'($urandom_range(0, 31));
      ed = $urandom();
      aa = 5'($urandom_range(0, 31));
      ad = $urandom();
      if ($urandom_range(0, 99) < 85) begin
        if (q.size() != 0) begin
          aa = q[0].a; ad = q[0].d;
        end else if (ev) begin
          aa = ea; ad = ed;
        end
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(ev, ea, ed, av, aa, ad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
